// File: rtl/pll_lock_supervisor.sv
// Reset sequencer and lock monitor for a vendor rPLL, clocked by the PLL reference clock.
// Defining PLL_SUP_LOSS_CNT_EN adds the saturating lock-loss counter and its loss_cnt port.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int LOSS_W        = 8,
  localparam int RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               lock,
  input  logic               restart,
  output logic               pll_reset,
  output logic               ready,
  output logic               rst_out,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SUP_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  loss_cnt
`endif
);

  localparam int MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_RS > LOCK_TIMEOUT) ? MAX_RS : LOCK_TIMEOUT;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_READY     = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  logic [2:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic [1:0]         sync_reg;
  logic               lock_s;

  // lock comes straight from the PLL analog block, so it is treated as asynchronous
  assign lock_s = sync_reg[1];

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    if (restart) begin
      state_next = S_RESET;
      retry_next = '0;
    end else begin
      case (state_reg)
        S_RESET: begin
          if (cnt_reg == CNT_W'(RST_CYCLES - 1)) state_next = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_next = S_STABLE;
          end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
            if (retry_reg == RETRY_W'(MAX_RETRY)) begin
              state_next = S_FAIL;
            end else begin
              retry_next = retry_reg + RETRY_W'(1);
              state_next = S_RESET;
            end
          end
        end
        S_STABLE: begin
          // a drop here keeps the retry budget but restarts the lock timeout window
          if (!lock_s) begin
            state_next = S_WAIT_LOCK;
          end else if (cnt_reg == CNT_W'(STABLE_CYCLES - 1)) begin
            state_next = S_READY;
            retry_next = '0;
          end
        end
        S_READY: begin
          if (!lock_s) state_next = S_RESET;
        end
        S_FAIL: begin
          state_next = S_FAIL;
        end
        default: begin
          state_next = S_RESET;
        end
      endcase
    end
    cnt_next = (restart || (state_next != state_reg)) ? '0 : cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_reg <= S_RESET;
      cnt_reg   <= '0;
      retry_reg <= '0;
      sync_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      sync_reg  <= {sync_reg[0], lock};
    end
  end

  assign pll_reset = (state_reg == S_RESET) || (state_reg == S_FAIL);
  assign ready     = (state_reg == S_READY);
  assign rst_out   = ~ready;
  assign fail      = (state_reg == S_FAIL);
  assign retry_cnt = retry_reg;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_reg;
  logic              loss_event;

  // restart from READY is a deliberate re-sequence, not a lock loss
  assign loss_event = (state_reg == S_READY) && !lock_s && !restart;

  always_ff @(posedge clkin) begin
    if (reset) begin
      loss_reg <= '0;
    end else if (loss_event && (loss_reg != {LOSS_W{1'b1}})) begin
      loss_reg <= loss_reg + LOSS_W'(1);
    end
  end

  assign loss_cnt = loss_reg;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus randomized lock
// waveforms against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  localparam int LOSS_W        = 3;
  localparam int LOSS_MAX      = (1 << LOSS_W) - 1;

  localparam int PH_RESET  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_READY  = 3;
  localparam int PH_FAIL   = 4;

  logic              clkin   = 1'b0;
  logic              reset   = 1'b1;
  logic              lock    = 1'b0;
  logic              restart = 1'b0;
  logic              pll_reset, ready, rst_out, fail;
  logic [1:0]        retry_cnt;
  logic [LOSS_W-1:0] loss_cnt;
  logic [5:0]        obs;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // reference model state: current phase, cycles spent in it, lock history
  int m_phase, m_time, m_retry, m_loss;
  bit m_lock_d1, m_lock_d2;

  always #5 clkin = ~clkin;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .LOSS_W       (LOSS_W)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .lock     (lock),
    .restart  (restart),
    .pll_reset(pll_reset),
    .ready    (ready),
    .rst_out  (rst_out),
    .fail     (fail),
    .retry_cnt(retry_cnt)
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    .loss_cnt (loss_cnt)
`endif
  );

`ifndef PLL_SUP_LOSS_CNT_EN
  assign loss_cnt = '0;
`endif

  assign obs = {pll_reset, ready, rst_out, fail, retry_cnt};

  task automatic tick();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  // after this, the next edge is cycle 0's edge and outputs show cycle 0
  task automatic do_reset(input logic lk);
    reset   = 1'b1;
    restart = 1'b0;
    lock    = lk;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  // one clock edge of the reference model with the inputs sampled at that edge
  task automatic model_edge(input bit rt, input bit rs, input bit lk);
    bit ls;
    int nxt;
    ls = m_lock_d2;
    if (rt) begin
      m_phase = PH_RESET; m_time = 0; m_retry = 0; m_loss = 0;
      m_lock_d1 = 1'b0; m_lock_d2 = 1'b0;
      return;
    end
    m_lock_d2 = m_lock_d1;
    m_lock_d1 = lk;
    nxt = m_phase;
    if (rs) begin
      nxt = PH_RESET;
      m_retry = 0;
    end else if (m_phase == PH_RESET) begin
      if (m_time + 1 == RST_CYCLES) nxt = PH_WAIT;
    end else if (m_phase == PH_WAIT) begin
      if (ls) nxt = PH_STABLE;
      else if (m_time + 1 == LOCK_TIMEOUT) begin
        if (m_retry == MAX_RETRY) nxt = PH_FAIL;
        else begin m_retry++; nxt = PH_RESET; end
      end
    end else if (m_phase == PH_STABLE) begin
      if (!ls) nxt = PH_WAIT;
      else if (m_time + 1 == STABLE_CYCLES) begin nxt = PH_READY; m_retry = 0; end
    end else if (m_phase == PH_READY) begin
      if (!ls) begin
        nxt = PH_RESET;
        if (m_loss < LOSS_MAX) m_loss++;
      end
    end
    m_time  = (rs || nxt != m_phase) ? 0 : m_time + 1;
    m_phase = nxt;
  endtask

  task automatic test_reset();
    reset = 1'b1; lock = 1'b1; restart = 1'b1;
    tick(); tick();
    vectors++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs, {1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
    end
`ifdef PLL_SUP_LOSS_CNT_EN
    vectors++;
    if (loss_cnt !== '0) begin
      errors++;
      $display("FAIL reset_loss_cnt: got %0d want 0", loss_cnt);
    end
`endif
    restart = 1'b0;
    $display("test_reset: reset values checked");
  endtask

  task automatic test_clean_lock();
    logic [5:0] exp;
    do_reset(1'b1);
    for (int c = 0; c <= 15; c++) begin
      exp = {c <= 3, c >= 13, c < 13, 1'b0, 2'd0};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL clean_lock cyc=%0d: got %b want %b", c, obs, exp);
      end
      tick();
    end
    $display("test_clean_lock: ready expected at cycle 13");
  endtask

  task automatic test_no_lock();
    logic [5:0] exp;
    do_reset(1'b0);
    for (int c = 0; c <= 82; c++) begin
      exp = {((c % 24) < 4) || (c >= 72), 1'b0, 1'b1, c >= 72,
             2'(c < 24 ? 0 : (c < 48 ? 1 : 2))};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL no_lock cyc=%0d: got %b want %b", c, obs, exp);
      end
      tick();
    end
    $display("test_no_lock: fail expected from cycle 72");
  endtask

  task automatic test_restart_from_fail();
    logic [5:0] exp;
    restart = 1'b1;
    lock    = 1'b1;
    tick();
    restart = 1'b0;
    for (int r = 0; r <= 14; r++) begin
      exp = {r <= 3, r >= 13, r < 13, 1'b0, 2'd0};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL restart_from_fail rel=%0d: got %b want %b", r, obs, exp);
      end
      tick();
    end
    $display("test_restart_from_fail: ready expected 13 cycles after restart");
  endtask

  task automatic test_glitch_in_stable();
    logic [5:0] exp;
    do_reset(1'b1);
    for (int c = 0; c <= 22; c++) begin
      exp = {c <= 3, c >= 20, c < 20, 1'b0, 2'd0};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL glitch_stable cyc=%0d: got %b want %b", c, obs, exp);
      end
      lock = (c != 8);
      tick();
    end
    $display("test_glitch_in_stable: ready delayed to cycle 20");
  endtask

  task automatic test_lock_loss();
    logic [5:0] exp;
    logic       rdy;
    do_reset(1'b1);
    for (int c = 0; c <= 38; c++) begin
      rdy = (c >= 13 && c <= 22) || (c >= 36);
      exp = {(c <= 3) || (c >= 23 && c <= 26), rdy, !rdy, 1'b0, 2'd0};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lock_loss cyc=%0d: got %b want %b", c, obs, exp);
      end
`ifdef PLL_SUP_LOSS_CNT_EN
      vectors++;
      if (loss_cnt !== LOSS_W'(c >= 23 ? 1 : 0)) begin
        errors++;
        $display("FAIL lock_loss_cnt cyc=%0d: got %0d want %0d", c, loss_cnt, (c >= 23 ? 1 : 0));
      end
`endif
      lock = !(c >= 20 && c <= 22);
      tick();
    end
    $display("test_lock_loss: loss at cycle 20, ready back at 36");
  endtask

  task automatic test_reset_mid_stable();
    logic [5:0] exp;
    restart = 1'b1;
    lock    = 1'b1;
    tick();
    restart = 1'b0;
    for (int r = 0; r <= 9; r++) begin
      exp = {r <= 3, 1'b0, 1'b1, 1'b0, 2'd0};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid_stable rel=%0d: got %b want %b", r, obs, exp);
      end
      tick();
    end
`ifdef PLL_SUP_LOSS_CNT_EN
    vectors++;
    if (loss_cnt !== LOSS_W'(1)) begin
      errors++;
      $display("FAIL reset_mid_stable_loss_before: got %0d want 1", loss_cnt);
    end
`endif
    reset = 1'b1;
    tick();
    vectors++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_mid_stable_outputs: got %b want %b", obs, {1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
    end
`ifdef PLL_SUP_LOSS_CNT_EN
    vectors++;
    if (loss_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_stable_loss_after: got %0d want 0", loss_cnt);
    end
`endif
    reset = 1'b0;
    $display("test_reset_mid_stable: reset applied in STABLE");
  endtask

  task automatic test_loss_saturation();
    do_reset(1'b1);
    repeat (13) tick();
    for (int i = 0; i < 9; i++) begin
      lock = 1'b0;
      repeat (3) tick();
      lock = 1'b1;
      repeat (13) tick();
      vectors++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL loss_sat_ready round=%0d: got %b want 1", i, ready);
      end
`ifdef PLL_SUP_LOSS_CNT_EN
      vectors++;
      if (loss_cnt !== LOSS_W'((i + 1) > LOSS_MAX ? LOSS_MAX : i + 1)) begin
        errors++;
        $display("FAIL loss_sat_cnt round=%0d: got %0d want %0d", i, loss_cnt,
                 ((i + 1) > LOSS_MAX ? LOSS_MAX : i + 1));
      end
`endif
    end
    $display("test_loss_saturation: 9 losses, counter saturates at %0d", LOSS_MAX);
  endtask

  task automatic test_random();
    logic [5:0] exp;
    int         seg_len;
    bit         lk, rs, rt;
    do_reset(1'b0);
    model_edge(1'b1, 1'b0, 1'b0);
    for (int s = 0; s < 150; s++) begin
      seg_len = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 40);
      lk      = ($urandom_range(0, 3) != 0);
      $display("txn %0d: lock=%0b for %0d cycles", s, lk, seg_len);
      for (int k = 0; k < seg_len; k++) begin
        rs = ($urandom_range(0, 63) == 0);
        rt = ($urandom_range(0, 499) == 0);
        lock = lk; restart = rs; reset = rt;
        model_edge(rt, rs, lk);
        tick();
        exp = {(m_phase == PH_RESET) || (m_phase == PH_FAIL), m_phase == PH_READY,
               m_phase != PH_READY, m_phase == PH_FAIL, 2'(m_retry)};
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random seg=%0d k=%0d: got %b want %b", s, k, obs, exp);
        end
`ifdef PLL_SUP_LOSS_CNT_EN
        vectors++;
        if (loss_cnt !== LOSS_W'(m_loss)) begin
          errors++;
          $display("FAIL random_loss seg=%0d k=%0d: got %0d want %0d", s, k, loss_cnt, m_loss);
        end
`endif
      end
    end
    restart = 1'b0;
    reset   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_no_lock();
    test_restart_from_fail();
    test_glitch_in_stable();
    test_lock_loss();
    test_reset_mid_stable();
    test_loss_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

- Parametrised sequencer and lock monitor for a vendor rPLL primitive; runs on the PLL reference clock.
- Drives the PLL `reset` pin and watches its `lock` output.
- Asserts `ready` and releases a downstream synchronous reset only after lock has been held continuously for a programmable time.
- Retries on lock timeout, re-sequences on lock loss, and latches a fail flag after a bounded number of retries.

## Interface
Parameters:
- RST_CYCLES, 16: cycles `pll_reset` is held high per attempt (≥1)
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before an attempt fails (≥1)
- STABLE_CYCLES, 1024: cycles `lock` must stay high before `ready` (≥1)
- MAX_RETRY, 3: retries after the first attempt before FAIL (≥0)
- LOSS_W, 8: width of the lock-loss counter

Ports:
- clkin  in  1  reference clock; sole clock of the block.
- reset  in  1  synchronous reset, active-high; overrides everything.
- lock  in  1  PLL lock; asynchronous; passes through a 2-flop synchroniser to `lock_s`.
- restart  in  1  single-cycle request to re-sequence from RESET.
- pll_reset  out  1  drives the PLL reset pin.
- ready  out  1  PLL locked and stable.
- rst_out  out  1  downstream reset, always equal to ~ready.
- fail  out  1  retries exhausted.
- retry_cnt  out  $clog2(MAX_RETRY+1)  retries used in the current sequence.
- loss_cnt  out  LOSS_W  saturating count of lock losses from READY. Present only with the macro.

## Operation
- Interval counter `cnt`:
  - Width is $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)).
  - Cleared on every state change.
- States:
  - RESET: `pll_reset`=1. When cnt==RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_reset`=0.
    - If lock_s=1, go to STABLE.
    - If cnt==LOCK_TIMEOUT-1 with lock_s=0 (timeout):
      - retry_cnt==MAX_RETRY: go to FAIL.
      - otherwise: retry_cnt+1, go to RESET.
  - STABLE:
    - If lock_s=0, go to WAIT_LOCK. retry_cnt is unchanged; the timeout window restarts.
    - If cnt==STABLE_CYCLES-1 with lock_s=1, go to READY and clear retry_cnt.
  - READY: `ready`=1. If lock_s=0, loss_cnt+1 (saturating at all-ones) and go to RESET.
  - FAIL: `pll_reset`=1 and `fail`=1. Stays here until `restart` or `reset`.
- Outputs are a Moore decode of the state register, with no added latency.
- `restart`=1 in any state:
  - Next state is RESET and retry_cnt is cleared.
  - Takes priority over every other transition in that cycle.
  - Does not increment loss_cnt, even from READY.
- `reset` during any operation returns all registers to their reset values on the next edge.
- Reset values:
  - state=RESET, cnt=0, sync flops=0.
  - pll_reset=1, ready=0, rst_out=1, fail=0.
  - retry_cnt=0, loss_cnt=0.

## Timing
- `lock` to `lock_s` latency: 2 cycles.
- Cycle 0 is the first edge after `reset` is sampled low. With `lock` already high for ≥2 cycles:
  - RESET occupies cycles 0..RST_CYCLES-1.
  - WAIT_LOCK occupies cycle RST_CYCLES.
  - STABLE runs for STABLE_CYCLES cycles.
  - `ready` first goes high at cycle RST_CYCLES+STABLE_CYCLES+1 (1041 with defaults).
- A lock drop in READY:
  - `ready` falls 3 cycles after the `lock` edge (2 sync + 1 state).
  - `pll_reset` rises in the same cycle that `ready` falls.
- Continuous no-lock:
  - Each attempt lasts RST_CYCLES+LOCK_TIMEOUT cycles.
  - FAIL is entered after MAX_RETRY+1 attempts, at cycle (MAX_RETRY+1)*(RST_CYCLES+LOCK_TIMEOUT).

## Configuration
- PLL_SUP_LOSS_CNT_EN defined: the `loss_cnt` port and register exist and behave as described above.
- Not defined:
  - Port and register are absent.
  - All state transitions are identical.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2, with the macro defined.
- Clean lock: `lock`=1 throughout. Required: `pll_reset` high for cycles 0-3; `ready` rises and `rst_out` falls at cycle 13; retry_cnt=0.
- No lock: `lock`=0 throughout. Required: retry_cnt steps 1→2; `fail`=1 and `pll_reset`=1 from cycle 72; the state holds.
- Restart from FAIL: after the previous scenario, pulse `restart` and set `lock`=1. Required: `fail`=0 next cycle; retry_cnt=0; `ready` 13 cycles after restart is sampled.
- Glitch in STABLE: `lock` low for 1 cycle at cycle 8. Required: return to WAIT_LOCK, STABLE restarts, `ready` delayed; no retry increment.
- Lock loss in READY: drop `lock` at cycle 20. Required: `ready`=0 and `pll_reset`=1 at cycle 23; loss_cnt=1; re-lock gives `ready` again after 13 further cycles.
- Reset mid-STABLE: assert `reset` at cycle 9. Required: all outputs return to reset values on the next edge; loss_cnt=0.
